// File: rtl/instr_aligner.sv
// Halfword realigner between instruction fetch and the RV32C decoder: buffers fetch
// words as halfwords and presents one whole 16- or 32-bit instruction per handshake.
module instr_aligner #(
   parameter logic [31:0] RESET_PC = 32'h1ECE_B000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_fetch_valid,
   output logic        o_fetch_ready,
   input  logic [31:0] i_fetch_data,
   input  logic [31:0] i_fetch_pc,
   input  logic        i_flush,
   input  logic [31:0] i_flush_pc,
   output logic        o_instr_valid,
   input  logic        i_instr_ready,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic        o_compressed
);

   logic [15:0] q_q [4];
   logic [15:0] q_d [4];
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  count_q, count_d;
   logic [31:0] head_pc_q, head_pc_d;
   logic [29:0] exp_pc_q, exp_pc_d;
   logic        skip_low_q, skip_low_d;

   logic [15:0] hw0, hw1;
   logic        compressed, instr_valid, fetch_ready;
   logic        pop, accept, match;
   logic [2:0]  pop_n, push_n;
   logic [1:0]  wr_ptr;

   always_comb begin
      hw0         = q_q[rd_ptr_q];
      hw1         = q_q[rd_ptr_q + 2'd1];
      compressed  = (hw0[1:0] != 2'b11);
      instr_valid = ((count_q != 3'd0) && compressed) || (count_q >= 3'd2);
      fetch_ready = (count_q <= 3'd2);
      pop         = instr_valid && i_instr_ready;
      pop_n       = pop ? (compressed ? 3'd1 : 3'd2) : 3'd0;
      accept      = i_fetch_valid && fetch_ready && !i_flush;
      match       = accept && (i_fetch_pc[31:2] == exp_pc_q);
      push_n      = match ? (skip_low_q ? 3'd1 : 3'd2) : 3'd0;
      // Accepting implies count <= 2, so the write slots never overlap the head being popped.
      wr_ptr      = rd_ptr_q + count_q[1:0];

      q_d        = q_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      head_pc_d  = head_pc_q;
      exp_pc_d   = exp_pc_q;
      skip_low_d = skip_low_q;

      if (i_flush) begin
         count_d    = 3'd0;
         rd_ptr_d   = 2'd0;
         head_pc_d  = i_flush_pc;
         exp_pc_d   = i_flush_pc[31:2];
         skip_low_d = i_flush_pc[1];
      end else begin
         if (match) begin
            if (skip_low_q) begin
               q_d[wr_ptr] = i_fetch_data[31:16];
            end else begin
               q_d[wr_ptr]         = i_fetch_data[15:0];
               q_d[wr_ptr + 2'd1]  = i_fetch_data[31:16];
            end
            exp_pc_d   = exp_pc_q + 30'd1;
            skip_low_d = 1'b0;
         end
         rd_ptr_d  = rd_ptr_q + pop_n[1:0];
         count_d   = count_q + push_n - pop_n;
         head_pc_d = head_pc_q + {28'd0, pop_n, 1'b0};
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < 4; i++) q_q[i] <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         head_pc_q  <= RESET_PC;
         exp_pc_q   <= RESET_PC[31:2];
         skip_low_q <= RESET_PC[1];
      end else begin
         q_q        <= q_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         head_pc_q  <= head_pc_d;
         exp_pc_q   <= exp_pc_d;
         skip_low_q <= skip_low_d;
      end
   end

   assign o_fetch_ready = fetch_ready;
   assign o_instr_valid = instr_valid;
   assign o_compressed  = compressed;
   assign o_instr       = compressed ? {16'd0, hw0} : {hw1, hw0};
   assign o_pc          = head_pc_q;

endmodule

// File: tb/tb_instr_aligner.sv
// Scoreboard bench for instr_aligner: the driver queues expected instructions, a
// negedge monitor pops and compares on every handshake.
module tb_instr_aligner;

   localparam logic [31:0] RPC = 32'h1ECE_B000;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_fetch_valid = 1'b0;
   logic        o_fetch_ready;
   logic [31:0] i_fetch_data = '0;
   logic [31:0] i_fetch_pc = '0;
   logic        i_flush = 1'b0;
   logic [31:0] i_flush_pc = '0;
   logic        o_instr_valid;
   logic        i_instr_ready = 1'b0;
   logic [31:0] o_instr;
   logic [31:0] o_pc;
   logic        o_compressed;

   instr_aligner #(.RESET_PC(RPC)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_fetch_valid(i_fetch_valid), .o_fetch_ready(o_fetch_ready),
      .i_fetch_data(i_fetch_data), .i_fetch_pc(i_fetch_pc),
      .i_flush(i_flush), .i_flush_pc(i_flush_pc),
      .o_instr_valid(o_instr_valid), .i_instr_ready(i_instr_ready),
      .o_instr(o_instr), .o_pc(o_pc), .o_compressed(o_compressed)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        c;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   task automatic expect_instr(input logic [31:0] instr, input logic [31:0] pc, input logic c);
      exp_t e;
      e.instr = instr;
      e.pc    = pc;
      e.c     = c;
      exp_q.push_back(e);
   endtask

   // Monitor: a handshake seen at the negedge completes on the next posedge.
   always @(negedge i_clk) begin
      if (!i_rst && !i_flush && o_instr_valid && i_instr_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got instr %h pc %h want none", o_instr, o_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("instr", o_instr, e.instr);
            chk("pc", o_pc, e.pc);
            chk("compressed", {31'd0, o_compressed}, {31'd0, e.c});
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic [31:0] data, input logic [31:0] pc);
      logic rdy;
      int   n;
      i_fetch_valid = 1'b1;
      i_fetch_data  = data;
      i_fetch_pc    = pc;
      n = 0;
      rdy = 1'b0;
      while (!rdy && n < 50) begin
         @(negedge i_clk);
         rdy = o_fetch_ready;
         tick();
         n++;
      end
      if (!rdy) chk("fetch_accept_timeout", 32'd0, 32'd1);
      i_fetch_valid = 1'b0;
   endtask

   task automatic flush(input logic [31:0] pc);
      i_flush    = 1'b1;
      i_flush_pc = pc;
      tick();
      i_flush = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      chk("drain_left", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      repeat (2) tick();
      // Reset state
      @(negedge i_clk);
      chk("rst_valid", {31'd0, o_instr_valid}, 32'd0);
      chk("rst_fetch_ready", {31'd0, o_fetch_ready}, 32'd1);
      chk("rst_pc", o_pc, RPC);
      tick();
      i_rst = 1'b0;
      i_instr_ready = 1'b1;
      tick();

      // 1: single 32-bit instruction
      expect_instr(32'h00A00093, RPC, 1'b0);
      send(32'h00A00093, RPC);
      drain();

      // 2: two compressed in one word
      flush(RPC);
      expect_instr(32'h00000485, RPC, 1'b1);
      expect_instr(32'h00004505, RPC + 32'd2, 1'b1);
      send(32'h45050485, RPC);
      drain();

      // 3: 32-bit instruction spanning two words with a gap
      flush(RPC);
      expect_instr(32'h00000001, RPC, 1'b1);
      send(32'h00930001, RPC);
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         chk("gap_valid", {31'd0, o_instr_valid}, 32'd0);
         tick();
      end
      expect_instr(32'h00A00093, RPC + 32'd2, 1'b0);
      expect_instr(32'h00000001, RPC + 32'd6, 1'b1);
      send(32'h000100A0, RPC + 32'd4);
      drain();

      // 4: flush to halfword target, stale word dropped
      flush(RPC + 32'h102);
      send(32'h12345678, RPC + 32'd4);
      @(negedge i_clk);
      chk("stale_valid", {31'd0, o_instr_valid}, 32'd0);
      tick();
      expect_instr(32'h00000485, RPC + 32'h102, 1'b1);
      send(32'h0485FFFF, RPC + 32'h100);
      drain();
      repeat (2) tick();

      // 5: backpressure fills the queue
      flush(RPC);
      i_instr_ready = 1'b0;
      expect_instr(32'h00000001, RPC, 1'b1);
      expect_instr(32'h00000005, RPC + 32'd2, 1'b1);
      expect_instr(32'h00000009, RPC + 32'd4, 1'b1);
      expect_instr(32'h0000000D, RPC + 32'd6, 1'b1);
      send(32'h00050001, RPC);
      send(32'h000D0009, RPC + 32'd4);
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         chk("full_fetch_ready", {31'd0, o_fetch_ready}, 32'd0);
         chk("hold_valid", {31'd0, o_instr_valid}, 32'd1);
         chk("hold_instr", o_instr, 32'h00000001);
         chk("hold_pc", o_pc, RPC);
         tick();
      end
      i_instr_ready = 1'b1;
      drain();
      repeat (2) tick();

      // 6: asynchronous reset with three halfwords buffered
      flush(RPC + 32'd2);
      i_instr_ready = 1'b0;
      send(32'h00050001, RPC);
      send(32'h000D0009, RPC + 32'd4);
      @(negedge i_clk);
      chk("pre_rst_valid", {31'd0, o_instr_valid}, 32'd1);
      @(posedge i_clk);
      #2 i_rst = 1'b1;
      #1;
      chk("async_rst_valid", {31'd0, o_instr_valid}, 32'd0);
      chk("async_rst_pc", o_pc, RPC);
      chk("async_rst_fetch_ready", {31'd0, o_fetch_ready}, 32'd1);
      #1 i_rst = 1'b0;
      tick();
      i_instr_ready = 1'b1;
      expect_instr(32'h00A00093, RPC, 1'b0);
      send(32'h00A00093, RPC);
      drain();

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
